// File: rtl/alu_sequencer_if.sv
// Handshake and strobe bundle between alu_sequencer, instruction ROM and the ALU datapath.
// iStep exists only when SEQ_SINGLE_STEP_EN is defined.
interface alu_sequencer_if;
  logic [9:0]  oInstrAddr;
  logic        oInstrReq;
  logic        iInstrValid;
  logic [15:0] iInstr;
  logic [15:0] oInstruction;
  logic        iWriteA;
  logic        iWriteB;
  logic        iReadA;
  logic        iReadB;
  logic        iRamWrite;
  logic        iCa;
  logic        iCb;
  logic        oWriteA;
  logic        oWriteB;
  logic        oLoadA;
  logic        oLoadB;
  logic        oRamWrite;
  logic        oCa;
  logic        oCb;
  logic        oHalted;
`ifdef SEQ_SINGLE_STEP_EN
  logic        iStep;
`endif

  modport master (
    input  iInstrValid, iInstr, iWriteA, iWriteB, iReadA, iReadB, iRamWrite, iCa, iCb,
`ifdef SEQ_SINGLE_STEP_EN
    input  iStep,
`endif
    output oInstrAddr, oInstrReq, oInstruction, oWriteA, oWriteB, oLoadA, oLoadB,
           oRamWrite, oCa, oCb, oHalted
  );

  modport slave (
    output iInstrValid, iInstr, iWriteA, iWriteB, iReadA, iReadB, iRamWrite, iCa, iCb,
`ifdef SEQ_SINGLE_STEP_EN
    output iStep,
`endif
    input  oInstrAddr, oInstrReq, oInstruction, oWriteA, oWriteB, oLoadA, oLoadB,
           oRamWrite, oCa, oCb, oHalted
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/execute sequencer for the 8-bit ALU: fetch, 1-cycle execute, load wait, halt.
// Optional feature: SEQ_SINGLE_STEP_EN adds iStep and a STEPWAIT state after every retirement.
module alu_sequencer #(
  parameter int          RAM_LAT  = 2,
  parameter logic [9:0]  RESET_PC = 10'h000,
  parameter logic [5:0]  OP_JMP   = 6'h3C,
  parameter logic [5:0]  OP_BCA   = 6'h3D,
  parameter logic [5:0]  OP_BCB   = 6'h3E,
  parameter logic [5:0]  OP_HALT  = 6'h3F
) (
  input logic             Clock,
  input logic             Reset,
  alu_sequencer_if.master bus
);

  localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(RAM_LAT - 1);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_EXEC    = 3'd1,
    S_MEMWAIT = 3'd2,
    S_HALT    = 3'd3
`ifdef SEQ_SINGLE_STEP_EN
    ,
    S_STEPWAIT = 3'd4
`endif
  } state_t;

`ifdef SEQ_SINGLE_STEP_EN
  localparam state_t S_RETIRE = S_STEPWAIT;
`else
  localparam state_t S_RETIRE = S_FETCH;
`endif

  state_t        state_q, state_d;
  logic [9:0]    pc_q, pc_d;
  logic [15:0]   instr_q, instr_d;
  logic          ca_q, ca_d;
  logic          cb_q, cb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ld_b_q, ld_b_d;

  logic          req_s;
  logic          wr_a_s, wr_b_s, ld_a_s, ld_b_s, ram_wr_s;
  logic [5:0]    opcode_s;
  logic [9:0]    target_s;
  logic [9:0]    pc_inc_s;

  assign opcode_s = instr_q[15:10];
  assign target_s = instr_q[9:0];
  assign pc_inc_s = pc_q + 10'd1;

  // State, PC, instruction latch, flags and load-latency counter.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
      ca_q    <= 1'b0;
      cb_q    <= 1'b0;
      cnt_q   <= '0;
      ld_b_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ca_q    <= ca_d;
      cb_q    <= cb_d;
      cnt_q   <= cnt_d;
      ld_b_q  <= ld_b_d;
    end
  end

  // Next-state and strobe decode; ALU requests are combinational, so the qualified
  // write strobes follow them within the EXEC cycle rather than a cycle later.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ca_d     = ca_q;
    cb_d     = cb_q;
    cnt_d    = cnt_q;
    ld_b_d   = ld_b_q;
    req_s    = 1'b0;
    wr_a_s   = 1'b0;
    wr_b_s   = 1'b0;
    ld_a_s   = 1'b0;
    ld_b_s   = 1'b0;
    ram_wr_s = 1'b0;

    case (state_q)
      S_FETCH: begin
        req_s = 1'b1;
        if (bus.iInstrValid) begin
          instr_d = bus.iInstr;
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_EXEC: begin
        if (opcode_s == OP_JMP) begin
          pc_d    = target_s;
          state_d = S_RETIRE;
        end else if (opcode_s == OP_BCA) begin
          pc_d    = ca_q ? target_s : pc_inc_s;
          state_d = S_RETIRE;
        end else if (opcode_s == OP_BCB) begin
          pc_d    = cb_q ? target_s : pc_inc_s;
          state_d = S_RETIRE;
        end else if (opcode_s == OP_HALT) begin
          state_d = S_HALT;
        end else if (bus.iReadA || bus.iReadB) begin
          pc_d    = pc_inc_s;
          cnt_d   = CNT_LOAD;
          ld_b_d  = !bus.iReadA;
          state_d = S_MEMWAIT;
        end else begin
          wr_a_s   = bus.iWriteA;
          wr_b_s   = bus.iWriteB;
          ram_wr_s = bus.iRamWrite;
          if (bus.iWriteA) begin
            ca_d = bus.iCa;
          end else begin
            ca_d = ca_q;
          end
          if (bus.iWriteB) begin
            cb_d = bus.iCb;
          end else begin
            cb_d = cb_q;
          end
          pc_d    = pc_inc_s;
          state_d = S_RETIRE;
        end
      end

      S_MEMWAIT: begin
        if (cnt_q == '0) begin
          ld_a_s  = !ld_b_q;
          ld_b_s  = ld_b_q;
          state_d = S_RETIRE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

`ifdef SEQ_SINGLE_STEP_EN
      S_STEPWAIT: begin
        if (bus.iStep) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_STEPWAIT;
        end
      end
`endif

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign bus.oInstrAddr   = pc_q;
  assign bus.oInstrReq    = req_s;
  assign bus.oInstruction = instr_q;
  assign bus.oWriteA      = wr_a_s;
  assign bus.oWriteB      = wr_b_s;
  assign bus.oLoadA       = ld_a_s;
  assign bus.oLoadB       = ld_b_s;
  assign bus.oRamWrite    = ram_wr_s;
  assign bus.oCa          = ca_q;
  assign bus.oCb          = cb_q;
  assign bus.oHalted      = (state_q == S_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: the bench plays ROM and ALU and predicts each instruction's effect.
module tb_alu_sequencer;
  localparam int         RAM_LAT = 2;
  localparam logic [5:0] OP_JMP  = 6'h3C;
  localparam logic [5:0] OP_BCA  = 6'h3D;
  localparam logic [5:0] OP_BCB  = 6'h3E;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [5:0] OP_ADDA = 6'h00;
  localparam logic [5:0] OP_LDA  = 6'h02;
  localparam logic [5:0] OP_LDB  = 6'h03;
  localparam logic [5:0] OP_STA  = 6'h04;
  localparam logic [5:0] OP_NOP  = 6'h05;

  logic Clock;
  logic Reset;
  int   checks;
  int   failures;

  logic [9:0] m_pc;
  logic       m_ca;
  logic       m_cb;

  alu_sequencer_if bus ();

  alu_sequencer #(.RAM_LAT(RAM_LAT)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ALU stand-in: opcode low bits select which request it raises; carries come from the operand bits.
  always_comb begin
    bus.iWriteA   = (bus.oInstruction[12:10] == 3'd0);
    bus.iWriteB   = (bus.oInstruction[12:10] == 3'd1);
    bus.iReadA    = (bus.oInstruction[12:10] == 3'd2);
    bus.iReadB    = (bus.oInstruction[12:10] == 3'd3);
    bus.iRamWrite = (bus.oInstruction[12:10] == 3'd4);
    bus.iCa       = bus.oInstruction[0];
    bus.iCb       = bus.oInstruction[1];
  end

  logic [4:0] stb;
  assign stb = {bus.oWriteA, bus.oWriteB, bus.oLoadA, bus.oLoadB, bus.oRamWrite};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_addr",  32'(bus.oInstrAddr), 32'h0);
    check("rst_instr", 32'(bus.oInstruction), 32'h0);
    check("rst_stb",   32'(stb), 32'h0);
    check("rst_flags", 32'({bus.oCa, bus.oCb}), 32'h0);
    check("rst_halt",  32'(bus.oHalted), 32'h0);
    check("rst_req",   32'(bus.oInstrReq), 32'h1);
  endtask

  // Fetch one instruction after `waits` idle ROM cycles and check everything it should cause.
  task automatic run_instr(input logic [15:0] ins, input int waits);
    logic [5:0] op;
    logic [2:0] kind;
    logic       ctrl;
    logic [4:0] exp_stb;
    logic [9:0] next_pc;
    op   = ins[15:10];
    kind = op[2:0];
    ctrl = (op == OP_JMP) || (op == OP_BCA) || (op == OP_BCB) || (op == OP_HALT);

    check("fetch_req",  32'(bus.oInstrReq), 32'h1);
    check("fetch_addr", 32'(bus.oInstrAddr), 32'(m_pc));
    for (int w = 0; w < waits; w++) begin
      bus.iInstrValid = 1'b0;
      tick();
      check("wait_req", 32'(bus.oInstrReq), 32'h1);
      check("wait_stb", 32'(stb), 32'h0);
    end
    bus.iInstr      = ins;
    bus.iInstrValid = 1'b1;
    tick();
    bus.iInstrValid = 1'b0;
    bus.iInstr      = 16'($urandom);

    check("exec_instr", 32'(bus.oInstruction), 32'(ins));
    check("exec_req",   32'(bus.oInstrReq), 32'h0);
    exp_stb = 5'b00000;
    next_pc = m_pc + 10'd1;
    if (op == OP_JMP) begin
      next_pc = ins[9:0];
    end else if (op == OP_BCA) begin
      if (m_ca) next_pc = ins[9:0];
    end else if (op == OP_BCB) begin
      if (m_cb) next_pc = ins[9:0];
    end else if (op == OP_HALT) begin
      next_pc = m_pc;
    end else if (kind == 3'd0) begin
      exp_stb = 5'b10000;
      m_ca    = ins[0];
    end else if (kind == 3'd1) begin
      exp_stb = 5'b01000;
      m_cb    = ins[1];
    end else if (kind == 3'd4) begin
      exp_stb = 5'b00001;
    end
    check("exec_stb", 32'(stb), 32'(exp_stb));
    tick();
    m_pc = next_pc;
    check("flags", 32'({bus.oCa, bus.oCb}), 32'({m_ca, m_cb}));

    if (op == OP_HALT) begin
      bus.iInstrValid = 1'b1;
      for (int h = 0; h < 20; h++) begin
        check("halt_state", 32'({bus.oHalted, bus.oInstrReq, stb}), 32'({1'b1, 1'b0, 5'b00000}));
        tick();
      end
      bus.iInstrValid = 1'b0;
      check("halt_addr", 32'(bus.oInstrAddr), 32'(m_pc));
    end else begin
      if (!ctrl && (kind == 3'd2 || kind == 3'd3)) begin
        for (int l = 0; l < RAM_LAT - 1; l++) begin
          check("memwait_stb", 32'(stb), 32'h0);
          tick();
        end
        check("load_stb", 32'(stb), (kind == 3'd2) ? 32'h04 : 32'h02);
        tick();
      end
`ifdef SEQ_SINGLE_STEP_EN
      bus.iInstrValid = 1'b1;
      for (int s = 0; s < 3; s++) begin
        check("step_noreq", 32'(bus.oInstrReq), 32'h0);
        tick();
      end
      bus.iInstrValid = 1'b0;
      bus.iStep = 1'b1;
      tick();
      bus.iStep = 1'b0;
`endif
      check("next_addr", 32'(bus.oInstrAddr), 32'(m_pc));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ins;
    checks          = 0;
    failures        = 0;
    Reset           = 1'b0;
    bus.iInstrValid = 1'b0;
    bus.iInstr      = 16'h0000;
`ifdef SEQ_SINGLE_STEP_EN
    bus.iStep       = 1'b0;
`endif
    m_pc = 10'h000;
    m_ca = 1'b0;
    m_cb = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check_reset_outputs();
    @(negedge Clock);
    Reset = 1'b1;
    tick();

    run_instr({OP_ADDA, 10'h001}, 0);
    run_instr({OP_BCA, 10'h155}, 0);
    run_instr({OP_JMP, 10'h3FF}, 1);
    run_instr({OP_BCB, 10'h020}, 0);
    run_instr({OP_LDB, 10'h000}, 0);
    for (int n = 0; n < 4; n++) run_instr({OP_NOP, 10'h000}, 0);
    run_instr({OP_STA, 10'h000}, 0);

    check("lda_addr", 32'(bus.oInstrAddr), 32'h6);
    bus.iInstr      = {OP_LDA, 10'h000};
    bus.iInstrValid = 1'b1;
    tick();
    bus.iInstrValid = 1'b0;
    tick();
    Reset = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge Clock);
    Reset = 1'b1;
    m_pc = 10'h000;
    m_ca = 1'b0;
    m_cb = 1'b0;
    tick();

    for (int r = 0; r < 150; r++) begin
      ins = 16'($urandom);
      if (ins[15:10] == OP_HALT) ins[15:10] = OP_NOP;
      run_instr(ins, int'($urandom_range(0, 2)));
    end
    run_instr({OP_HALT, 10'h2AA}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
